// File: rtl/rs_block_framer.sv
// Splits a TX payload byte stream into RS_K-byte message blocks, zero-pads a short final block,
// and appends RS_N-RS_K empty check-symbol slots so the RS encoder can fill in parity.
module rs_block_framer #(
  parameter int RS_N = 255,
  parameter int RS_K = 239
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_data_valid,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic [7:0] o_rs_en_data,
  output logic       o_rs_en_data_valid,
  output logic       o_rs_en_sof,
  output logic       o_rs_en_eof,
  output logic       o_rs_en_chk
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAD,
    CHECK
  } state_t;

  // Index of the last message symbol and of the last codeword symbol.
  localparam logic [8:0] K_LAST = 9'(RS_K - 1);
  localparam logic [8:0] N_LAST = 9'(RS_N - 1);

  state_t     state;
  logic [8:0] sym_cnt;
  logic       acc;

  assign o_tx_ready = (state == IDLE) || (state == DATA);
  assign acc        = i_tx_data_valid & o_tx_ready;

  // While in DATA/PAD/CHECK, sym_cnt is the index of the symbol being emitted this cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state              <= IDLE;
      sym_cnt            <= 9'd0;
      o_rs_en_data       <= 8'h00;
      o_rs_en_data_valid <= 1'b0;
      o_rs_en_sof        <= 1'b0;
      o_rs_en_eof        <= 1'b0;
      o_rs_en_chk        <= 1'b0;
    end else begin
      o_rs_en_data       <= 8'h00;
      o_rs_en_data_valid <= 1'b0;
      o_rs_en_sof        <= 1'b0;
      o_rs_en_eof        <= 1'b0;
      o_rs_en_chk        <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            o_rs_en_data       <= i_tx_data;
            o_rs_en_data_valid <= 1'b1;
            o_rs_en_sof        <= 1'b1;
            sym_cnt            <= 9'd1;
            if (RS_K == 1) begin
              state <= CHECK;
            end else if (i_tx_last) begin
              state <= PAD;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (acc) begin
            o_rs_en_data       <= i_tx_data;
            o_rs_en_data_valid <= 1'b1;
            sym_cnt            <= sym_cnt + 9'd1;
            // A full block takes priority over last: no padding is needed then.
            if (sym_cnt == K_LAST) begin
              state <= CHECK;
            end else if (i_tx_last) begin
              state <= PAD;
            end
          end
        end
        PAD: begin
          o_rs_en_data_valid <= 1'b1;
          sym_cnt            <= sym_cnt + 9'd1;
          if (sym_cnt == K_LAST) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          o_rs_en_data_valid <= 1'b1;
          o_rs_en_chk        <= 1'b1;
          if (sym_cnt == N_LAST) begin
            o_rs_en_eof <= 1'b1;
            sym_cnt     <= 9'd0;
            state       <= IDLE;
          end else begin
            sym_cnt <= sym_cnt + 9'd1;
          end
        end
        default: begin
          state   <= IDLE;
          sym_cnt <= 9'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_block_framer.sv
// Directed bench for rs_block_framer: drives payload frames and checks every output symbol
// and the ready flag cycle by cycle against the expected codeword layout.
module tb_rs_block_framer;

  localparam int RS_N = 255;
  localparam int RS_K = 239;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [7:0] rs_data;
  logic       rs_valid;
  logic       rs_sof;
  logic       rs_eof;
  logic       rs_chk;

  int checks = 0;
  int errors = 0;
  int sofCount;
  int eofCount;
  int readyLowCount;

  rs_block_framer #(.RS_N(RS_N), .RS_K(RS_K)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_tx_data          (tx_data),
    .i_tx_data_valid    (tx_valid),
    .i_tx_last          (tx_last),
    .o_tx_ready         (tx_ready),
    .o_rs_en_data       (rs_data),
    .o_rs_en_data_valid (rs_valid),
    .o_rs_en_sof        (rs_sof),
    .o_rs_en_eof        (rs_eof),
    .o_rs_en_chk        (rs_chk)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One clock: drive inputs, check ready for this cycle, then check the symbol registered at the edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic expReady,
                               input logic expValid, input logic [7:0] expData,
                               input logic expSof, input logic expEof, input logic expChk);
    tx_valid = v;
    tx_data  = d;
    tx_last  = l;
    checkOutput("ready", {31'b0, tx_ready}, {31'b0, expReady});
    if (!tx_ready) readyLowCount++;
    @(posedge clk);
    #1;
    checkOutput("sym", {20'b0, rs_valid, rs_sof, rs_eof, rs_chk, rs_data},
                {20'b0, expValid, expSof, expEof, expChk, expData});
    if (rs_sof) sofCount++;
    if (rs_eof) eofCount++;
  endtask

  // Sends len bytes (base+i); gaps inserts an idle cycle between bytes; abortAt>=0 stops before that byte.
  task automatic sendFrame(input int len, input bit gaps, input int base, input int abortAt);
    int sent;
    int n;
    logic [7:0] b;
    sent = 0;
    while (sent < len) begin
      n = (len - sent > RS_K) ? RS_K : (len - sent);
      for (int j = 0; j < n; j++) begin
        if (sent + j == abortAt) return;
        b = 8'(base + sent + j);
        if (gaps && j > 0) applyStimulus(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, b, (sent + j == len - 1), 1'b1, 1'b1, b, (j == 0), 1'b0, 1'b0);
      end
      for (int j = n; j < RS_K; j++)
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int j = RS_K; j < RS_N; j++)
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, (j == RS_N - 1), 1'b1);
      sent += n;
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic clearCounts();
    sofCount      = 0;
    eofCount      = 0;
    readyLowCount = 0;
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    tx_last  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_sym", {24'b0, rs_valid, rs_sof, rs_eof, rs_chk, 4'b0}, 32'h0);
    checkOutput("reset_data", {24'b0, rs_data}, 32'h0);
    checkOutput("reset_ready", {31'b0, tx_ready}, 32'h1);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_valid", {31'b0, rs_valid}, 32'h0);

    $display("[TB] full block, continuous valid");
    clearCounts();
    sendFrame(239, 1'b0, 0, -1);
    checkOutput("t1_ready_low", readyLowCount, 16);
    checkOutput("t1_sof", sofCount, 1);
    checkOutput("t1_eof", eofCount, 1);

    $display("[TB] short block of 10 bytes");
    clearCounts();
    sendFrame(10, 1'b0, 1, -1);
    checkOutput("t2_ready_low", readyLowCount, 245);
    checkOutput("t2_eof", eofCount, 1);

    $display("[TB] full block, valid toggling");
    clearCounts();
    sendFrame(239, 1'b1, 0, -1);
    checkOutput("t3_ready_low", readyLowCount, 16);
    checkOutput("t3_sof", sofCount, 1);

    $display("[TB] 500-byte stream");
    clearCounts();
    sendFrame(500, 1'b0, 0, -1);
    checkOutput("t4_sof", sofCount, 3);
    checkOutput("t4_eof", eofCount, 3);
    checkOutput("t4_ready_low", readyLowCount, 16 + 16 + 217 + 16);

    $display("[TB] single byte");
    clearCounts();
    sendFrame(1, 1'b0, 8'h5A, -1);
    checkOutput("t5_ready_low", readyLowCount, 254);
    checkOutput("t5_eof", eofCount, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset mid-codeword");
    clearCounts();
    sendFrame(239, 1'b0, 0, 100);
    rst_n    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h33;
    tx_last  = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_reset_sym", {20'b0, rs_valid, rs_sof, rs_eof, rs_chk, rs_data}, 32'h0);
    checkOutput("t6_reset_ready", {31'b0, tx_ready}, 32'h1);
    if (rs_eof) eofCount++;
    @(posedge clk);
    #1;
    checkOutput("t6_reset_hold", {20'b0, rs_valid, rs_sof, rs_eof, rs_chk, rs_data}, 32'h0);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    rst_n    = 1'b1;
    sendFrame(239, 1'b0, 0, -1);
    checkOutput("t6_sof", sofCount, 2);
    checkOutput("t6_eof", eofCount, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
